contador_decrescente: RTL and testbench

CONTADOR_DECRESCENTE -- requirements
Module: contador_decrescente

---
 rtl/contador_decrescente_pkg.sv | 38 +++
 rtl/contador_decrescente_if.sv | 22 ++
 rtl/contador_decrescente_tff_cell.sv | 38 +++
 rtl/contador_decrescente.sv | 88 ++++++++
 tb/tb_contador_decrescente.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/contador_decrescente_pkg.sv
// Shared constants for the down counter: default parameters, 7-segment
// codes (active-low, bit order {g,f,e,d,c,b,a}) and the counter state type.
package contador_decrescente_pkg;

    localparam int unsigned DIV_DEFAULT   = 2;
    localparam logic [2:0]  START_DEFAULT = 3'd7;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;

    // RUN: counting (q != 0, or wrap enabled); HOLD: parked at 0 with wrap off
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } cnt_state_t;

    function automatic logic [6:0] seg_encode(input logic [2:0] v);
        logic [6:0] s;
        case (v)
            3'd0:    s = SEG_0;
            3'd1:    s = SEG_1;
            3'd2:    s = SEG_2;
            3'd3:    s = SEG_3;
            3'd4:    s = SEG_4;
            3'd5:    s = SEG_5;
            3'd6:    s = SEG_6;
            default: s = SEG_7;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/contador_decrescente_if.sv
// Control inputs and count/display outputs of the down counter.
interface contador_decrescente_if;

    logic       en;
    logic       load;
    logic       wrap;
    logic [2:0] q;
    logic       zero;
    logic       done;
    logic [6:0] seg;

    modport master (
        output en, load, wrap,
        input  q, zero, done, seg
    );

    modport slave (
        input  en, load, wrap,
        output q, zero, done, seg
    );

endinterface

// File: rtl/contador_decrescente_tff_cell.sv
// One count bit: T flip-flop with async clear to a preset value and a
// synchronous load that takes precedence over toggling.
module tff_cell #(
    parameter logic PRESET = 1'b0
) (
    input  logic clk,
    input  logic clr,
    input  logic t,
    input  logic d_load,
    input  logic ld,
    output logic q
);

    logic bit_q;
    logic bit_d;

    // load override ahead of the toggle cell
    always_comb begin
        bit_d = bit_q;
        if (ld) begin
            bit_d = d_load;
        end else if (t) begin
            bit_d = ~bit_q;
        end
    end

    // state bit, cleared to its preset asynchronously
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            bit_q <= PRESET;
        end else begin
            bit_q <= bit_d;
        end
    end

    assign q = bit_q;

endmodule

// File: rtl/contador_decrescente.sv
// 3-bit down counter with prescaler, wrap/saturate mode, done pulse and
// 7-segment decode. Count bits are T flip-flops; the wrap reload and the
// external load share the cells' load path.
module contador_decrescente
    import contador_decrescente_pkg::*;
#(
    parameter int unsigned DIV   = DIV_DEFAULT,
    parameter logic [2:0]  START = START_DEFAULT
) (
    input logic             clk,
    input logic             clr,
    contador_decrescente_if.slave bus
);

    localparam logic [7:0] PRESC_TC = 8'(DIV - 1);

    logic [7:0] presc_q;
    logic [7:0] presc_d;
    logic       done_q;
    logic       done_d;
    logic [2:0] cnt_q;
    logic [2:0] t_vec;
    logic       tick;
    logic       step_dec;
    logic       wrap_ld;
    logic       ld;
    cnt_state_t state;

    assign tick  = bus.en && (presc_q == PRESC_TC);
    assign state = ((cnt_q == 3'd0) && !bus.wrap) ? ST_HOLD : ST_RUN;

    // classify the step: plain decrement, wrap reload, or nothing (HOLD / load)
    always_comb begin
        step_dec = 1'b0;
        wrap_ld  = 1'b0;
        if (!bus.load && tick) begin
            if (cnt_q != 3'd0) begin
                step_dec = 1'b1;
            end else if (state == ST_RUN) begin
                wrap_ld = 1'b1;
            end
        end
        ld     = bus.load || wrap_ld;
        t_vec  = {step_dec & ~cnt_q[1] & ~cnt_q[0], step_dec & ~cnt_q[0], step_dec};
        // done flags a step that lands on 0; a reload lands on 0 only if START is 0
        done_d = (step_dec && (cnt_q == 3'd1)) || (wrap_ld && (START == 3'd0));
    end

    // prescaler next value: cleared by load, frozen while en is low
    always_comb begin
        presc_d = presc_q;
        if (bus.load) begin
            presc_d = 8'd0;
        end else if (bus.en) begin
            presc_d = (presc_q == PRESC_TC) ? 8'd0 : presc_q + 8'd1;
        end
    end

    // prescaler and done pulse registers
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            presc_q <= 8'd0;
            done_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            done_q  <= bus.load ? 1'b0 : done_d;
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_bit
        tff_cell #(
            .PRESET (START[i])
        ) u_bit (
            .clk    (clk),
            .clr    (clr),
            .t      (t_vec[i]),
            .d_load (START[i]),
            .ld     (ld),
            .q      (cnt_q[i])
        );
    end

    assign bus.q    = cnt_q;
    assign bus.zero = (cnt_q == 3'd0);
    assign bus.done = done_q;
    assign bus.seg  = seg_encode(cnt_q);

endmodule

// File: tb/tb_contador_decrescente.sv
// Self-checking bench: directed scenarios with literal expectations plus
// randomized traffic against a behavioural model of the counter.
module tb_contador_decrescente;

    localparam int unsigned DIV   = 2;
    localparam logic [2:0]  START = 3'd7;

    logic clk = 1'b0;
    logic clr = 1'b0;

    contador_decrescente_if bus_if ();

    contador_decrescente #(
        .DIV   (DIV),
        .START (START)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [8] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000};

    int n_chk  = 0;
    int n_fail = 0;
    bit cmp_on = 1'b0;

    // behavioural model
    int mq = 7;
    int mp = 0;
    bit md = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    // model update from the inputs present at each edge
    always @(posedge clk or posedge clr) begin
        if (clr) begin
            mq = int'(START);
            mp = 0;
            md = 1'b0;
        end else if (bus_if.load) begin
            mq = int'(START);
            mp = 0;
            md = 1'b0;
        end else begin
            md = 1'b0;
            if (bus_if.en) begin
                if (mp == int'(DIV) - 1) begin
                    mp = 0;
                    if (mq != 0) begin
                        mq = mq - 1;
                        md = (mq == 0);
                    end else if (bus_if.wrap) begin
                        mq = int'(START);
                        md = (START == 3'd0);
                    end
                end else begin
                    mp = mp + 1;
                end
            end
        end
    end

    // compare DUT against the model every cycle, away from the rising edge
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("model_q",    int'(bus_if.q),    mq);
            chk("model_zero", int'(bus_if.zero), int'(mq == 0));
            chk("model_done", int'(bus_if.done), int'(md));
            chk("model_seg",  int'(bus_if.seg),  int'(seg_tab[mq]));
        end
    end

    task automatic cyc(input bit e, input bit l, input bit w);
        bus_if.en   = e;
        bus_if.load = l;
        bus_if.wrap = w;
        @(posedge clk);
        #1;
    endtask

    int dones;

    initial begin
        bus_if.en   = 1'b0;
        bus_if.load = 1'b0;
        bus_if.wrap = 1'b0;
        #2 clr = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_q",    int'(bus_if.q),    7);
        chk("reset_done", int'(bus_if.done), 0);
        chk("reset_seg",  int'(bus_if.seg),  int'(7'b1111000));
        clr    = 1'b0;
        cmp_on = 1'b1;

        // saturating countdown
        cyc(1, 0, 0);
        chk("sat_first_hold", int'(bus_if.q), 7);
        cyc(1, 0, 0);
        chk("sat_first_step", int'(bus_if.q), 6);
        repeat (12) cyc(1, 0, 0);
        chk("sat_reach0_q",    int'(bus_if.q),    0);
        chk("sat_reach0_done", int'(bus_if.done), 1);
        cyc(1, 0, 0);
        chk("sat_done_1cyc", int'(bus_if.done), 0);
        repeat (4) cyc(1, 0, 0);
        chk("sat_hold_q",    int'(bus_if.q),    0);
        chk("sat_hold_done", int'(bus_if.done), 0);

        // wrapping: 7..0,7..0,7..4
        cyc(0, 1, 1);
        dones = 0;
        for (int i = 0; i < 38; i++) begin
            cyc(1, 0, 1);
            if (bus_if.done) dones++;
        end
        chk("wrap_q",     int'(bus_if.q), 4);
        chk("wrap_dones", dones,          2);

        // load on a tick edge at q=3
        cyc(0, 1, 0);
        repeat (8) cyc(1, 0, 0);
        chk("ldtick_pre_q", int'(bus_if.q), 3);
        cyc(1, 0, 0);
        cyc(1, 1, 0);
        chk("ldtick_q",    int'(bus_if.q),    7);
        chk("ldtick_done", int'(bus_if.done), 0);
        cyc(1, 0, 0);
        chk("ldtick_presc_clr", int'(bus_if.q), 7);
        cyc(1, 0, 0);
        chk("ldtick_next_step", int'(bus_if.q), 6);

        // enable pattern 1,0,0,1
        cyc(0, 1, 0);
        cyc(1, 0, 0);
        chk("en_c1", int'(bus_if.q), 7);
        cyc(0, 0, 0);
        chk("en_c2", int'(bus_if.q), 7);
        cyc(0, 0, 0);
        chk("en_c3", int'(bus_if.q), 7);
        cyc(1, 0, 0);
        chk("en_c4", int'(bus_if.q), 6);

        // asynchronous clear mid-cycle at q=2
        cyc(0, 1, 0);
        repeat (10) cyc(1, 0, 0);
        chk("aclr_pre_q", int'(bus_if.q), 2);
        bus_if.en = 1'b0;
        #2 clr = 1'b1;
        #1;
        chk("aclr_q",    int'(bus_if.q),    7);
        chk("aclr_seg",  int'(bus_if.seg),  int'(7'b1111000));
        chk("aclr_zero", int'(bus_if.zero), 0);
        @(posedge clk);
        #3 clr = 1'b0;
        cyc(1, 0, 0);
        chk("aclr_rel_c1", int'(bus_if.q), 7);
        cyc(1, 0, 0);
        chk("aclr_rel_c2", int'(bus_if.q), 6);

        // sweep all values through the display decode
        cyc(0, 1, 0);
        for (int k = 0; k < 8; k++) begin
            chk("sweep_q",    int'(bus_if.q),    7 - k);
            chk("sweep_seg",  int'(bus_if.seg),  int'(seg_tab[7 - k]));
            chk("sweep_zero", int'(bus_if.zero), int'(k == 7));
            cyc(1, 0, 0);
            cyc(1, 0, 0);
        end

        // randomized traffic against the model
        bus_if.wrap = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            bit e;
            bit l;
            bit w;
            e = ($urandom_range(0, 9) < 7);
            l = ($urandom_range(0, 49) == 0);
            w = bus_if.wrap;
            if ($urandom_range(0, 39) == 0) w = ~w;
            if ($urandom_range(0, 99) == 0) begin
                bus_if.en   = e;
                bus_if.load = l;
                bus_if.wrap = w;
                #2 clr = 1'b1;
                #3 clr = 1'b0;
                @(posedge clk);
                #1;
            end else begin
                cyc(e, l, w);
            end
        end

        cmp_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
